// File: rtl/aes_inv_cipher_iter_if.sv
// Block request/response bus and round-key lookup for the iterative AES-128 inverse cipher.
interface aes_inv_cipher_iter_if;
  logic         en;
  logic         start_i;
  logic [127:0] ct_i;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic [127:0] pt_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output en, start_i, ct_i, rk_i,
    input  rk_idx_o, pt_o, busy_o, done_o
  );

  modport slave (
    input  en, start_i, ct_i, rk_i,
    output rk_idx_o, pt_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per enabled clock, round keys
// fetched combinationally from external key storage by index.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  aes_inv_cipher_iter_if.slave        bus
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic [127:0] st, st_nxt;
  logic [127:0] pt, pt_nxt;
  logic [127:0] rnd_ak, rnd_mc;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; s[r][c] is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a     = col[31-8*k -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a;
      mb[k] = x8 ^ x2 ^ a;
      md[k] = x8 ^ x4 ^ a;
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  always_comb begin
    rnd_ak = inv_sub_bytes(inv_shift_rows(st)) ^ bus.rk_i;
    rnd_mc = inv_mix_columns(rnd_ak);
  end

  always_comb begin
    fsm_nxt = fsm;
    cnt_nxt = cnt;
    st_nxt  = st;
    pt_nxt  = pt;
    case (fsm)
      IDLE: begin
        if (bus.start_i) begin
          st_nxt  = bus.ct_i ^ bus.rk_i;
          cnt_nxt = 4'(NR - 1);
          fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        // Last round skips InvMixColumns and lands straight in the output register.
        if (cnt == 4'd0) begin
          pt_nxt  = rnd_ak;
          fsm_nxt = DONE;
        end else begin
          st_nxt  = rnd_mc;
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      cnt <= 4'd0;
      st  <= '0;
      pt  <= '0;
    end else if (bus.en) begin
      fsm <= fsm_nxt;
      cnt <= cnt_nxt;
      st  <= st_nxt;
      pt  <= pt_nxt;
    end
  end

  assign bus.rk_idx_o = (fsm == ROUND) ? cnt : 4'(NR);
  assign bus.busy_o   = (fsm == ROUND);
  assign bus.done_o   = (fsm == DONE);
  assign bus.pt_o     = pt;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors with tabulated round keys.
module tb_aes_inv_cipher_iter;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk;
  logic rst_n;
  logic key_sel;
  logic [127:0] rk_c1 [0:15];
  logic [127:0] rk_b  [0:15];
  int checks;
  int errors;
  int n;

  aes_inv_cipher_iter_if bus ();

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rk_i = key_sel ? rk_b[bus.rk_idx_o] : rk_c1[bus.rk_idx_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents start_i for one edge; that edge counts as cycle 1 of the operation.
  task automatic pulse_start(input logic [127:0] ct, input logic sel);
    key_sel     = sel;
    bus.ct_i    = ct;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int cyc);
    cyc = n0;
    while (bus.done_o !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) begin
      rk_c1[i] = '0;
      rk_b[i]  = '0;
    end
    rk_c1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_c1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_c1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_c1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_c1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_c1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_c1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_c1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_c1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_c1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_c1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rk_b[0]   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_b[1]   = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_b[2]   = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_b[3]   = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_b[4]   = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_b[5]   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_b[6]   = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_b[7]   = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_b[8]   = 128'head27321b58dbad2312bf5607f8d292f;
    rk_b[9]   = 128'hac7766f319fadc2128d12941575c006e;
    rk_b[10]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    key_sel     = 1'b0;
    bus.en      = 1'b1;
    bus.start_i = 1'b0;
    bus.ct_i    = '0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    step();
    step();
    check("rst_pt",     bus.pt_o, '0);
    check("rst_busy",   128'(bus.busy_o), 128'(0));
    check("rst_done",   128'(bus.done_o), 128'(0));
    check("rst_rk_idx", 128'(bus.rk_idx_o), 128'(10));
    rst_n = 1'b1;
    step();

    // C.1 with per-cycle key index and latency tracking
    check("c1_idle_rk_idx", 128'(bus.rk_idx_o), 128'(10));
    pulse_start(CT_C1, 1'b0);
    check("c1_rk_idx_1", 128'(bus.rk_idx_o), 128'(9));
    check("c1_busy_1",   128'(bus.busy_o), 128'(1));
    for (int k = 2; k <= 10; k++) begin
      step();
      check($sformatf("c1_rk_idx_%0d", k), 128'(bus.rk_idx_o), 128'(10 - k));
      check($sformatf("c1_done_early_%0d", k), 128'(bus.done_o), 128'(0));
    end
    step();
    check("c1_done_11",   128'(bus.done_o), 128'(1));
    check("c1_busy_11",   128'(bus.busy_o), 128'(0));
    check("c1_rk_idx_11", 128'(bus.rk_idx_o), 128'(10));
    check("c1_pt",        bus.pt_o, PT_C1);
    step();
    check("c1_done_pulse_end", 128'(bus.done_o), 128'(0));
    check("c1_pt_hold",        bus.pt_o, PT_C1);

    // App. B, then a second start held through the DONE cycle
    pulse_start(CT_B, 1'b1);
    wait_done(1, n);
    check("b_latency", 128'(n), 128'(11));
    check("b_pt",      bus.pt_o, PT_B);
    key_sel     = 1'b0;
    bus.ct_i    = CT_C1;
    bus.start_i = 1'b1;
    step();
    check("b2_start_ignored_in_done", 128'(bus.busy_o), 128'(0));
    step();
    bus.start_i = 1'b0;
    check("b2_started", 128'(bus.busy_o), 128'(1));
    wait_done(1, n);
    check("b2_latency", 128'(n), 128'(11));
    check("b2_pt",      bus.pt_o, PT_C1);
    step();

    // Enable low for 3 cycles at round index 5; also freeze the done pulse
    pulse_start(CT_C1, 1'b0);
    for (int k = 2; k <= 5; k++) step();
    check("en_rk_idx_before", 128'(bus.rk_idx_o), 128'(5));
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("en_frozen_rk_idx_%0d", k), 128'(bus.rk_idx_o), 128'(5));
      check($sformatf("en_frozen_busy_%0d", k), 128'(bus.busy_o), 128'(1));
    end
    bus.en = 1'b1;
    wait_done(8, n);
    check("en_latency", 128'(n), 128'(14));
    check("en_pt",      bus.pt_o, PT_C1);
    bus.en = 1'b0;
    step();
    step();
    check("en_done_held", 128'(bus.done_o), 128'(1));
    bus.en = 1'b1;
    step();
    check("en_done_cleared", 128'(bus.done_o), 128'(0));

    // Start pulse with other data while busy must be dropped
    pulse_start(CT_B, 1'b1);
    for (int k = 2; k <= 4; k++) step();
    bus.ct_i    = CT_C1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    wait_done(5, n);
    check("busy_start_latency", 128'(n), 128'(11));
    check("busy_start_pt",      bus.pt_o, PT_B);
    for (int k = 0; k < 14; k++) begin
      step();
      check($sformatf("busy_start_no_second_done_%0d", k), 128'(bus.done_o), 128'(0));
    end
    check("busy_start_idle", 128'(bus.busy_o), 128'(0));

    // Asynchronous reset at round index 4
    pulse_start(CT_C1, 1'b0);
    for (int k = 2; k <= 6; k++) step();
    check("rst_mid_rk_idx_before", 128'(bus.rk_idx_o), 128'(4));
    rst_n = 1'b0;
    #1;
    check("rst_mid_pt",     bus.pt_o, '0);
    check("rst_mid_busy",   128'(bus.busy_o), 128'(0));
    check("rst_mid_done",   128'(bus.done_o), 128'(0));
    check("rst_mid_rk_idx", 128'(bus.rk_idx_o), 128'(10));
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("rst_mid_no_done_%0d", k), 128'(bus.done_o), 128'(0));
    end
    pulse_start(CT_B, 1'b1);
    wait_done(1, n);
    check("rst_mid_restart_latency", 128'(n), 128'(11));
    check("rst_mid_restart_pt",      bus.pt_o, PT_B);
    step();

    // start_i already high when reset is released
    rst_n       = 1'b0;
    key_sel     = 1'b0;
    bus.ct_i    = CT_C1;
    bus.start_i = 1'b1;
    step();
    check("rel_pt_cleared", bus.pt_o, '0);
    rst_n = 1'b1;
    step();
    bus.start_i = 1'b0;
    check("rel_started", 128'(bus.busy_o), 128'(1));
    wait_done(1, n);
    check("rel_latency", 128'(n), 128'(11));
    check("rel_pt",      bus.pt_o, PT_C1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
